sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Parametrised N-channel request arbiter in front of the SDRAM controller; generalises the fixed ch0 (PPU) / ch1 (CPU) / ch2 (save RAM) wiring into NUM_CH latched channels.
- Each channel gets pulse-style read/write strobes, a per-channel busy flag and a held read-data register.
- Adds selectable fixed-priority or round-robin grant, refresh slot insertion, and overrun detection. Sits between the NES core/loader/save logic and the single-command SDRAM backend.

Parameters:
- NUM_CH, 3, number of requesting channels (2..8); channel 0 is highest priority in fixed mode.
- ADDR_W, 25, byte address width per channel and on the backend.
- DATA_W, 8, data width per channel and on the backend.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock (SDRAM domain).
- reset  in  1  asynchronous active-high reset.
- ch_addr  in  NUM_CH*ADDR_W  packed channel addresses; channel i occupies [i*ADDR_W +: ADDR_W].
- ch_din  in  NUM_CH*DATA_W  packed write data.
- ch_rd  in  NUM_CH  one-cycle read strobes.
- ch_wr  in  NUM_CH  one-cycle write strobes.
- ch_dout  out  NUM_CH*DATA_W  per-channel last read data, held until the next read on that channel completes.
- ch_busy  out  NUM_CH  channel request pending or in flight.
- ch_overrun  out  NUM_CH  sticky flag: strobe dropped while the channel was in flight.
- refresh  in  1  refresh request pulse from the core.
- mem_req  out  1  backend command valid; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_refresh  out  1  refresh command; held with mem_req.
- mem_addr  out  ADDR_W  command address.
- mem_din  out  DATA_W  command write data.
- mem_dout  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion (write done, read data valid, or refresh done).

Behaviour:
- Reset: all outputs 0; pending, in-flight and latched registers cleared; state IDLE; rr pointer 0. Reset mid-transaction aborts it; a late mem_ack arriving after reset is ignored (state IDLE).
- Capture: a strobe on channel i at edge k latches addr, din and we into slot i; pending[i] = 1 from k+1. If ch_rd and ch_wr coincide, the write wins.
- A strobe on a pending channel that is not yet granted overwrites the slot and raises no overrun.
- A strobe on the in-flight channel is dropped and sets ch_overrun[i]; the flag clears only on reset.
- ch_busy[i] = pending[i] | in_flight[i]; it rises at k+1.
- refresh pulse sets refresh_pend; it clears when the refresh command is acked. Extra pulses while pending merge into one.
- FSM states IDLE, CMD, RFSH:
  - IDLE: if refresh_pend, go to RFSH. Otherwise, if any channel is pending, grant one and go to CMD. Refresh always beats channels.
  - Fixed priority (RR_MODE=0): grant the lowest pending index.
  - Round-robin (RR_MODE=1): grant the first pending index at or after rr_ptr, with wrap-around mod NUM_CH.
  - CMD: mem_req = 1; mem_addr, mem_we and mem_din come from the granted slot and stay stable until mem_ack.
  - On mem_ack in CMD: if read, ch_dout[g] <= mem_dout. Clear pending/in-flight for g; rr_ptr <= (g+1) mod NUM_CH; return to IDLE.
  - RFSH: mem_req = mem_refresh = 1, mem_we = 0, until mem_ack; then IDLE.
- mem_ack seen in IDLE is ignored.
- Latency: strobe at edge k gives mem_req high from k+2 when idle. mem_ack at edge a gives ch_dout/ch_busy update visible at a+1. The next mem_req is asserted at a+2 (one idle cycle minimum between commands).
- A channel strobe arriving in the same cycle as its completion ack is a new request: it is captured, pending is set, and no overrun is raised.

Test Plan:
- Single read: ch_rd[1] with addr 0x0001234, backend acks 3 cycles after mem_req with 0xA5 -> mem_addr = 0x0001234, mem_we = 0, ch_dout[1] = 0xA5, ch_busy[1] low one cycle after ack.
- Fixed priority: RR_MODE=0, ch_wr[2] and ch_rd[0] in the same cycle -> channel 0 is serviced first, then channel 2 with mem_we = 1 and mem_din = ch_din[2].
- Round-robin: RR_MODE=1, all 3 channels kept pending continuously -> grant order 0,1,2,0,1,2 with no channel starved.
- Refresh precedence: refresh pulse together with ch_rd[0] -> RFSH command (mem_refresh = 1) issued first, then the read; a second refresh pulse while pending yields only one refresh command.
- Overrun: ch_wr[0] strobed again while channel 0 is in flight -> ch_overrun[0] = 1 and the second write is never issued. Strobe before grant -> last data written, no overrun.
- Reset mid-command: assert reset while mem_req = 1 -> all outputs 0 immediately; a later stray mem_ack is ignored; ch_busy stays 0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// N-channel latched request arbiter feeding a single-command SDRAM backend.
// Fixed-priority or round-robin grant, refresh slot insertion, per-channel overrun flags.
module sdram_port_arbiter #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  input  logic [NUM_CH-1:0]        ch_rd,
  input  logic [NUM_CH-1:0]        ch_wr,
  output logic [NUM_CH*DATA_W-1:0] ch_dout,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_overrun,
  input  logic                     refresh,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_refresh,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout,
  input  logic                     mem_ack
);

  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, CMD, RFSH} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                refresh_pend_q, refresh_pend_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   inflight_q, inflight_d;
  logic [NUM_CH-1:0]   overrun_q, overrun_d;
  logic [NUM_CH-1:0]   we_q, we_d;
  logic [ADDR_W-1:0]   addr_q [NUM_CH];
  logic [ADDR_W-1:0]   addr_d [NUM_CH];
  logic [DATA_W-1:0]   din_q  [NUM_CH];
  logic [DATA_W-1:0]   din_d  [NUM_CH];
  logic [DATA_W-1:0]   dout_q [NUM_CH];
  logic [DATA_W-1:0]   dout_d [NUM_CH];

  logic                pick_valid;
  logic [CW-1:0]       pick_idx;
  logic [CW-1:0]       rr_idx;
  logic                done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      rr_ptr_q       <= '0;
      refresh_pend_q <= 1'b0;
      pending_q      <= '0;
      inflight_q     <= '0;
      overrun_q      <= '0;
      we_q           <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        addr_q[i] <= '0;
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      rr_ptr_q       <= rr_ptr_d;
      refresh_pend_q <= refresh_pend_d;
      pending_q      <= pending_d;
      inflight_q     <= inflight_d;
      overrun_q      <= overrun_d;
      we_q           <= we_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        addr_q[i] <= addr_d[i];
        din_q[i]  <= din_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  // Round-robin scans from rr_ptr with wrap; fixed mode scans from index 0.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    rr_idx     = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (RR_MODE != 0) begin
        rr_idx = CW'((32'(rr_ptr_q) + j) % NUM_CH);
      end else begin
        rr_idx = CW'(j);
      end
      if (!pick_valid && pending_q[rr_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (refresh_pend_q) begin
          state_d = RFSH;
        end else if (pick_valid) begin
          state_d = CMD;
          grant_d = pick_idx;
        end
      end
      CMD:     if (mem_ack) state_d = IDLE;
      RFSH:    if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion is applied before capture so a strobe in the ack cycle re-arms the slot;
  // grant is applied last so a strobe on the grant edge merges into the issued command.
  always_comb begin
    done           = (state_q == CMD) && mem_ack;
    rr_ptr_d       = rr_ptr_q;
    refresh_pend_d = refresh_pend_q;
    pending_d      = pending_q;
    inflight_d     = inflight_q;
    overrun_d      = overrun_q;
    we_d           = we_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      addr_d[i] = addr_q[i];
      din_d[i]  = din_q[i];
      dout_d[i] = dout_q[i];
    end

    if (done) begin
      inflight_d[grant_q] = 1'b0;
      if (!we_q[grant_q]) dout_d[grant_q] = mem_dout;
      rr_ptr_d = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + CW'(1);
    end
    if ((state_q == RFSH) && mem_ack) refresh_pend_d = 1'b0;
    if (refresh) refresh_pend_d = 1'b1;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_rd[i] || ch_wr[i]) begin
        if (inflight_d[i]) begin
          overrun_d[i] = 1'b1;
        end else begin
          addr_d[i]    = ch_addr[i*ADDR_W +: ADDR_W];
          din_d[i]     = ch_din[i*DATA_W +: DATA_W];
          we_d[i]      = ch_wr[i];
          pending_d[i] = 1'b1;
        end
      end
    end

    if ((state_q == IDLE) && (state_d == CMD)) begin
      pending_d[grant_d]  = 1'b0;
      inflight_d[grant_d] = 1'b1;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_refresh = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    case (state_q)
      CMD: begin
        mem_req  = 1'b1;
        mem_we   = we_q[grant_q];
        mem_addr = addr_q[grant_q];
        mem_din  = din_q[grant_q];
      end
      RFSH: begin
        mem_req     = 1'b1;
        mem_refresh = 1'b1;
      end
      default: ;
    endcase
    ch_busy    = pending_q | inflight_q;
    ch_overrun = overrun_q;
    ch_dout    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_dout[i*DATA_W +: DATA_W] = dout_q[i];
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: fixed-priority instance (a_*) driven from a vector table plus corner
// sequences, and a round-robin instance (b_*) for grant-order checks.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [74:0] a_addr;
  logic [23:0] a_din, a_dout;
  logic [2:0]  a_rd, a_wr, a_busy, a_ovr;
  logic        a_ref, a_req, a_we, a_mref, a_ack;
  logic [24:0] a_maddr;
  logic [7:0]  a_mdin, a_mdout;

  logic [74:0] b_addr;
  logic [23:0] b_din, b_dout;
  logic [2:0]  b_rd, b_wr, b_busy, b_ovr;
  logic        b_ref, b_req, b_we, b_mref, b_ack;
  logic [24:0] b_maddr;
  logic [7:0]  b_mdin, b_mdout;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_CH(3), .ADDR_W(25), .DATA_W(8), .RR_MODE(0)) u_fix (
    .clk(clk), .reset(rst), .ch_addr(a_addr), .ch_din(a_din), .ch_rd(a_rd), .ch_wr(a_wr),
    .ch_dout(a_dout), .ch_busy(a_busy), .ch_overrun(a_ovr), .refresh(a_ref),
    .mem_req(a_req), .mem_we(a_we), .mem_refresh(a_mref), .mem_addr(a_maddr),
    .mem_din(a_mdin), .mem_dout(a_mdout), .mem_ack(a_ack));

  sdram_port_arbiter #(.NUM_CH(3), .ADDR_W(25), .DATA_W(8), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(rst), .ch_addr(b_addr), .ch_din(b_din), .ch_rd(b_rd), .ch_wr(b_wr),
    .ch_dout(b_dout), .ch_busy(b_busy), .ch_overrun(b_ovr), .refresh(b_ref),
    .mem_req(b_req), .mem_we(b_we), .mem_refresh(b_mref), .mem_addr(b_maddr),
    .mem_din(b_mdin), .mem_dout(b_mdout), .mem_ack(b_ack));

  typedef struct {
    int unsigned ch;
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic [7:0]  rdata;
    int unsigned dly;
  } vec_t;

  vec_t        vecs [6];
  logic [7:0]  exp_dout [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic strobe_a(input int unsigned ch, input logic we,
                          input logic [24:0] addr, input logic [7:0] din);
    a_addr[ch*25 +: 25] = addr;
    a_din[ch*8 +: 8]    = din;
    if (we) a_wr[ch] = 1'b1;
    else    a_rd[ch] = 1'b1;
    tick();
    a_rd = '0;
    a_wr = '0;
  endtask

  task automatic ack_a(input logic [7:0] data);
    a_ack   = 1'b1;
    a_mdout = data;
    tick();
    a_ack   = 1'b0;
    a_mdout = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 1'b0, 25'h0001234, 8'h00, 8'hA5, 3};
    vecs[1] = '{0, 1'b1, 25'h0000000, 8'hFF, 8'h00, 0};
    vecs[2] = '{2, 1'b0, 25'h1FFFFFF, 8'h00, 8'h3C, 1};
    vecs[3] = '{2, 1'b1, 25'h0ABCDEF, 8'h00, 8'h00, 2};
    vecs[4] = '{0, 1'b0, 25'h1000001, 8'h00, 8'hFF, 0};
    vecs[5] = '{1, 1'b0, 25'h0000002, 8'h00, 8'h5A, 1};
    for (int i = 0; i < 3; i++) exp_dout[i] = 8'h00;

    rst = 1'b1;
    a_addr = '0; a_din = '0; a_rd = '0; a_wr = '0; a_ref = 1'b0; a_ack = 1'b0; a_mdout = '0;
    b_addr = '0; b_din = '0; b_rd = '0; b_wr = '0; b_ref = 1'b0; b_ack = 1'b0; b_mdout = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_req",   {63'd0, a_req}, 64'd0);
    chk("rst_busy",  {61'd0, a_busy}, 64'd0);
    chk("rst_dout",  {40'd0, a_dout}, 64'd0);
    chk("rst_ovr",   {61'd0, a_ovr}, 64'd0);
    chk("rst_maddr", {39'd0, a_maddr}, 64'd0);
    chk("rst_mref",  {63'd0, a_mref}, 64'd0);

    // Table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      strobe_a(vecs[v].ch, vecs[v].we, vecs[v].addr, vecs[v].din);
      chk("vec_busy_rise", {63'd0, a_busy[vecs[v].ch]}, 64'd1);
      chk("vec_req_k1",    {63'd0, a_req}, 64'd0);
      tick();
      chk("vec_req_k2",    {63'd0, a_req}, 64'd1);
      chk("vec_maddr",     {39'd0, a_maddr}, {39'd0, vecs[v].addr});
      chk("vec_we",        {63'd0, a_we}, {63'd0, vecs[v].we});
      chk("vec_mref",      {63'd0, a_mref}, 64'd0);
      if (vecs[v].we) chk("vec_mdin", {56'd0, a_mdin}, {56'd0, vecs[v].din});
      for (int d = 0; d < int'(vecs[v].dly); d++) tick();
      chk("vec_req_held",  {63'd0, a_req}, 64'd1);
      chk("vec_maddr_hold", {39'd0, a_maddr}, {39'd0, vecs[v].addr});
      if (!vecs[v].we) exp_dout[vecs[v].ch] = vecs[v].rdata;
      ack_a(vecs[v].rdata);
      chk("vec_busy_fall", {63'd0, a_busy[vecs[v].ch]}, 64'd0);
      chk("vec_req_drop",  {63'd0, a_req}, 64'd0);
      for (int c = 0; c < 3; c++)
        chk("vec_dout", {56'd0, a_dout[c*8 +: 8]}, {56'd0, exp_dout[c]});
    end

    // Fixed priority: ch2 write and ch0 read strobed together
    a_addr[0 +: 25]  = 25'h0000100;
    a_addr[50 +: 25] = 25'h0000200;
    a_din[16 +: 8]   = 8'h3C;
    a_rd = 3'b001; a_wr = 3'b100;
    tick();
    a_rd = '0; a_wr = '0;
    tick();
    chk("prio_first_addr", {39'd0, a_maddr}, 64'h100);
    chk("prio_first_we",   {63'd0, a_we}, 64'd0);
    ack_a(8'h11);
    chk("prio_dout0",      {56'd0, a_dout[7:0]}, 64'h11);
    chk("prio_busy2",      {63'd0, a_busy[2]}, 64'd1);
    chk("prio_idle_gap",   {63'd0, a_req}, 64'd0);
    tick();
    chk("prio_second_req", {63'd0, a_req}, 64'd1);
    chk("prio_second_addr", {39'd0, a_maddr}, 64'h200);
    chk("prio_second_we",  {63'd0, a_we}, 64'd1);
    chk("prio_second_din", {56'd0, a_mdin}, 64'h3C);
    ack_a(8'h00);
    chk("prio_busy_clear", {61'd0, a_busy}, 64'd0);

    // Refresh precedence and merging
    a_addr[0 +: 25] = 25'h0000055;
    a_ref = 1'b1; a_rd = 3'b001;
    tick();
    a_ref = 1'b0; a_rd = '0;
    tick();
    chk("rfsh_req",   {63'd0, a_req}, 64'd1);
    chk("rfsh_mref",  {63'd0, a_mref}, 64'd1);
    chk("rfsh_we",    {63'd0, a_we}, 64'd0);
    a_ref = 1'b1;
    tick();
    a_ref = 1'b0;
    ack_a(8'h00);
    chk("rfsh_gap",   {63'd0, a_req}, 64'd0);
    tick();
    chk("rfsh_rd_req",  {63'd0, a_req}, 64'd1);
    chk("rfsh_rd_mref", {63'd0, a_mref}, 64'd0);
    chk("rfsh_rd_addr", {39'd0, a_maddr}, 64'h55);
    ack_a(8'h66);
    chk("rfsh_rd_dout", {56'd0, a_dout[7:0]}, 64'h66);
    tick(); tick(); tick();
    chk("rfsh_merged",  {63'd0, a_req}, 64'd0);

    // Overrun on in-flight channel; overwrite of a pending, ungranted channel
    strobe_a(0, 1'b0, 25'h0000010, 8'h00);
    tick();
    chk("ovr_ch0_addr", {39'd0, a_maddr}, 64'h10);
    strobe_a(2, 1'b1, 25'h0000020, 8'h01);
    a_addr[0 +: 25] = 25'h0000030;
    a_din[0 +: 8]   = 8'h77;
    a_din[16 +: 8]  = 8'h02;
    a_wr = 3'b101;
    tick();
    a_wr = '0;
    chk("ovr_flag",     {61'd0, a_ovr}, 64'b001);
    chk("ovr_addr_hold", {39'd0, a_maddr}, 64'h10);
    ack_a(8'h9A);
    chk("ovr_dout0",    {56'd0, a_dout[7:0]}, 64'h9A);
    tick();
    chk("ovr_ch2_addr", {39'd0, a_maddr}, 64'h20);
    chk("ovr_ch2_we",   {63'd0, a_we}, 64'd1);
    chk("ovr_ch2_din",  {56'd0, a_mdin}, 64'h02);
    // strobe in the completion cycle is a fresh request
    a_addr[50 +: 25] = 25'h0000040;
    a_rd = 3'b100;
    ack_a(8'h00);
    a_rd = '0;
    chk("ackcyc_busy2", {63'd0, a_busy[2]}, 64'd1);
    chk("ackcyc_ovr",   {61'd0, a_ovr}, 64'b001);
    tick();
    chk("ackcyc_addr",  {39'd0, a_maddr}, 64'h40);
    chk("ackcyc_we",    {63'd0, a_we}, 64'd0);
    ack_a(8'h5E);
    chk("ackcyc_dout2", {56'd0, a_dout[23:16]}, 64'h5E);
    tick(); tick(); tick();
    chk("ovr_dropped",  {63'd0, a_req}, 64'd0);
    chk("ovr_busy0",    {61'd0, a_busy}, 64'd0);

    // Round-robin: keep all channels pending, re-strobe each in its ack cycle
    for (int c = 0; c < 3; c++) b_addr[c*25 +: 25] = 25'(c * 16 + 1);
    b_rd = 3'b111;
    tick();
    b_rd = '0;
    for (int n = 0; n < 6; n++) begin
      int k;
      int unsigned e;
      k = 0;
      while (!b_req && k < 20) begin
        tick();
        k++;
      end
      chk("rr_req", {63'd0, b_req}, 64'd1);
      e = n % 3;
      chk("rr_grant", {39'd0, b_maddr}, 64'(e * 16 + 1));
      b_ack = 1'b1;
      b_mdout = 8'(n);
      b_rd[e] = 1'b1;
      tick();
      b_ack = 1'b0;
      b_rd = '0;
    end

    // Reset mid-command, then a stray ack
    strobe_a(1, 1'b0, 25'h0000077, 8'h00);
    tick();
    chk("rmid_req_before", {63'd0, a_req}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rmid_req",   {63'd0, a_req}, 64'd0);
    chk("rmid_busy",  {61'd0, a_busy}, 64'd0);
    chk("rmid_dout",  {40'd0, a_dout}, 64'd0);
    chk("rmid_ovr",   {61'd0, a_ovr}, 64'd0);
    chk("rmid_maddr", {39'd0, a_maddr}, 64'd0);
    tick();
    rst = 1'b0;
    ack_a(8'hEE);
    chk("stray_dout", {40'd0, a_dout}, 64'd0);
    chk("stray_busy", {61'd0, a_busy}, 64'd0);
    chk("stray_req",  {63'd0, a_req}, 64'd0);
    tick();
    chk("stray_req2", {63'd0, a_req}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
